// File: rtl/ctrl.sv
// ----------------------------------------------------------------------------
// ctrl: shared definitions for the DataPath controller.
//   - Opcode constants for the 16-bit instruction word (opcode = IR[15:12])
//   - ALU command encoding and the opcode -> ALU command mapping
//   - CtrlSig bundle driven from the sequencer into the DataPath
//   - SeqState, the fetch/decode/execute FSM state encoding
// ----------------------------------------------------------------------------
package ctrl;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_ALU_FIRST = 4'h1;
  localparam logic [3:0] OP_ALU_LAST  = 4'h8;
  localparam logic [3:0] OP_LDI       = 4'h9;
  localparam logic [3:0] OP_JMP       = 4'hE;
  localparam logic [3:0] OP_HLT       = 4'hF;

  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SHL = 4'h6,
    ALU_SHR = 4'h7,
    ALU_NOT = 4'h8
  } AluCmd;

  localparam AluCmd ALU_CMD_DEFAULT = ALU_NOP;

  typedef struct packed {
    logic  reg_wr_en;
    AluCmd alu_cmd;
    logic  dst_in_sel;  // 0: ALU result, 1: immediate
  } CtrlSig;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } SeqState;

  // Opcodes outside the ALU range map to the default (no-op) command.
  function automatic AluCmd op_to_alu(input logic [3:0] op);
    case (op)
      4'h1:    return ALU_ADD;
      4'h2:    return ALU_SUB;
      4'h3:    return ALU_AND;
      4'h4:    return ALU_OR;
      4'h5:    return ALU_XOR;
      4'h6:    return ALU_SHL;
      4'h7:    return ALU_SHR;
      4'h8:    return ALU_NOT;
      default: return ALU_CMD_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode: combinational opcode decoder.
//   opcode   in  4        IR[15:12]
//   exec     in  1        high only while the sequencer is in EXEC
//   ctrl_sig out CtrlSig  DataPath control; all-zero unless exec=1
//   is_jmp   out 1        EXEC of a JMP
//   is_hlt   out 1        EXEC of a HLT
// Reserved opcodes (0xA-0xD) fall through as NOP.
// ----------------------------------------------------------------------------
module instr_decode
  import ctrl::*;
(
  input  logic [3:0] opcode,
  input  logic       exec,
  output CtrlSig     ctrl_sig,
  output logic       is_jmp,
  output logic       is_hlt
);

  always_comb begin
    ctrl_sig            = '0;
    ctrl_sig.alu_cmd    = ALU_CMD_DEFAULT;
    is_jmp              = 1'b0;
    is_hlt              = 1'b0;
    if (exec) begin
      if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
        ctrl_sig.alu_cmd   = op_to_alu(opcode);
        ctrl_sig.reg_wr_en = 1'b1;
      end else if (opcode == OP_LDI) begin
        ctrl_sig.dst_in_sel = 1'b1;
        ctrl_sig.reg_wr_en  = 1'b1;
      end else if (opcode == OP_JMP) begin
        is_jmp = 1'b1;
      end else if (opcode == OP_HLT) begin
        is_hlt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// ----------------------------------------------------------------------------
// dp_sequencer: fetch/decode/execute controller for the 8-bit DataPath.
//   clk, rst    clock and synchronous active-high reset
//   run         level; allows fetching to start / continue
//   imem_req    fetch request, held until imem_valid
//   imem_addr   fetch address (= pc)
//   imem_valid  instruction word valid (sampled only in FETCH)
//   imem_data   16-bit instruction word
//   operands    IR[11:0] to DataPath
//   ctrl_sig    decoded control to DataPath (all-zero outside EXEC)
//   pc          program counter
//   busy        FETCH or EXEC
//   halted      HALT; left only through rst
// One instruction per 2 cycles with zero-wait memory.
// ----------------------------------------------------------------------------
module dp_sequencer
  import ctrl::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [11:0]     operands,
  output CtrlSig          ctrl_sig,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  SeqState         state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            is_jmp, is_hlt;

  instr_decode u_decode (
    .opcode   (ir_q[15:12]),
    .exec     (state_q == S_EXEC),
    .ctrl_sig (ctrl_sig),
    .is_jmp   (is_jmp),
    .is_hlt   (is_hlt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        // run is deliberately not checked: a started fetch always completes.
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_hlt) begin
          state_d = S_HALT;
        end else begin
          pc_d    = is_jmp ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_HALT;
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with state_q without combinational decode on the ports.
    imem_req_d = (state_d == S_FETCH);
    busy_d     = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign operands  = ir_q[11:0];
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dp_sequencer: directed bench for dp_sequencer (PC_W=8, RESET_PC=0).
// The bench plays the instruction memory by hand, cycle by cycle.
// ----------------------------------------------------------------------------
module tb_dp_sequencer;
  import ctrl::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [11:0] operands;
  CtrlSig      ctrl_sig;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  dp_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .operands   (operands),
    .ctrl_sig   (ctrl_sig),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    step();
    step();

    // Reset state
    check("rst_req",    32'(imem_req), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_pc",     32'(pc), 0);
    check("rst_ops",    32'(operands), 0);
    check("rst_ctrl",   32'(ctrl_sig), 0);

    // LDI 0x9305 at addr 0, zero-wait memory
    rst = 1'b0;
    run = 1'b1;
    step();
    check("ldi_req",  32'(imem_req), 1);
    check("ldi_addr", 32'(imem_addr), 0);
    check("ldi_busy", 32'(busy), 1);
    imem_valid = 1'b1;
    imem_data  = 16'h9305;
    step();
    imem_valid = 1'b0;
    check("ldi_wr",   32'(ctrl_sig.reg_wr_en), 1);
    check("ldi_sel",  32'(ctrl_sig.dst_in_sel), 1);
    check("ldi_ops",  32'(operands), 32'h305);
    check("ldi_req0", 32'(imem_req), 0);
    step();
    check("ldi_pc",   32'(pc), 1);
    check("ldi_wr0",  32'(ctrl_sig.reg_wr_en), 0);
    check("f1_req",   32'(imem_req), 1);

    // ALU 0x1412 at addr 1 with 3 wait cycles (req held 4 cycles total)
    for (int i = 0; i < 3; i++) begin
      step();
      check("alu_wait_req",  32'(imem_req), 1);
      check("alu_wait_addr", 32'(imem_addr), 1);
      check("alu_wait_wr",   32'(ctrl_sig.reg_wr_en), 0);
    end
    imem_valid = 1'b1;
    imem_data  = 16'h1412;
    step();
    imem_valid = 1'b0;
    check("alu_wr",  32'(ctrl_sig.reg_wr_en), 1);
    check("alu_sel", 32'(ctrl_sig.dst_in_sel), 0);
    check("alu_cmd", 32'(ctrl_sig.alu_cmd), 32'h1);  // op 1 -> ADD
    step();
    check("alu_one_pulse", 32'(ctrl_sig.reg_wr_en), 0);
    check("alu_pc",        32'(pc), 2);

    // Reserved opcode 0xB123 at addr 2
    imem_valid = 1'b1;
    imem_data  = 16'hB123;
    step();
    imem_valid = 1'b0;
    check("rsv_wr",   32'(ctrl_sig.reg_wr_en), 0);
    check("rsv_busy", 32'(busy), 1);
    step();
    check("rsv_pc",   32'(pc), 3);

    // Program {NOP@0, JMP FE@1, NOP@FE, NOP@FF, HLT@0}
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("prg_pc0", 32'(pc), 32'h00);
    imem_valid = 1'b1; imem_data = 16'h0000; step(); imem_valid = 1'b0;
    check("prg_nop_wr", 32'(ctrl_sig.reg_wr_en), 0);
    step();
    check("prg_pc1", 32'(pc), 32'h01);
    imem_valid = 1'b1; imem_data = 16'hE0FE; step(); imem_valid = 1'b0;
    check("prg_jmp_wr", 32'(ctrl_sig.reg_wr_en), 0);
    step();
    check("prg_pcFE", 32'(pc), 32'hFE);
    check("prg_addrFE", 32'(imem_addr), 32'hFE);
    imem_valid = 1'b1; imem_data = 16'h0000; step(); imem_valid = 1'b0;
    step();
    check("prg_pcFF", 32'(pc), 32'hFF);
    imem_valid = 1'b1; imem_data = 16'h0000; step(); imem_valid = 1'b0;
    step();
    check("prg_wrap", 32'(pc), 32'h00);
    imem_valid = 1'b1; imem_data = 16'hF000; step(); imem_valid = 1'b0;
    check("hlt_wr", 32'(ctrl_sig.reg_wr_en), 0);
    step();
    check("hlt_halted", 32'(halted), 1);
    check("hlt_busy",   32'(busy), 0);
    check("hlt_req",    32'(imem_req), 0);
    check("hlt_pc",     32'(pc), 32'h00);
    for (int i = 0; i < 10; i++) begin
      imem_valid = i[0];
      imem_data  = 16'h9111;
      step();
      check("hlt_stay", 32'(halted), 1);
      check("hlt_stay_req", 32'(imem_req), 0);
    end
    imem_valid = 1'b0;

    // rst in HALT returns to IDLE
    run = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hrst_halted", 32'(halted), 0);
    check("hrst_busy",   32'(busy), 0);
    step();
    check("idle_req", 32'(imem_req), 0);

    // run dropped mid-FETCH: instruction still executes, then IDLE
    run = 1'b1;
    step();
    check("drop_req", 32'(imem_req), 1);
    run = 1'b0;
    step();
    check("drop_req_held", 32'(imem_req), 1);
    imem_valid = 1'b1; imem_data = 16'h9A55; step(); imem_valid = 1'b0;
    check("drop_exec_wr", 32'(ctrl_sig.reg_wr_en), 1);
    check("drop_exec_ops", 32'(operands), 32'hA55);
    step();
    check("drop_idle_req",  32'(imem_req), 0);
    check("drop_idle_busy", 32'(busy), 0);
    check("drop_idle_pc",   32'(pc), 1);
    step();
    check("drop_idle_req2", 32'(imem_req), 0);
    run = 1'b1;
    step();
    check("resume_req",  32'(imem_req), 1);
    check("resume_addr", 32'(imem_addr), 1);

    // rst during FETCH, late imem_valid lands in IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    run = 1'b0;
    check("frst_req", 32'(imem_req), 0);
    check("frst_pc",  32'(pc), 0);
    check("frst_ir",  32'(operands), 0);
    imem_valid = 1'b1;
    imem_data  = 16'h9777;
    step();
    imem_valid = 1'b0;
    check("late_wr",   32'(ctrl_sig.reg_wr_en), 0);
    check("late_ops",  32'(operands), 0);
    check("late_busy", 32'(busy), 0);
    check("late_req",  32'(imem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit DataPath.
- Fetches 16-bit instructions over a simple request/valid instruction-memory port and holds them in an instruction register (IR).
- Drives `operands[11:0]` and a `ctrl::CtrlSig` bundle (`reg_wr_en`, `alu_cmd`, `dst_in_sel`) into the DataPath.
- Maintains the program counter and handles NOP, jump and halt.

Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  level; start fetching from IDLE
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  PC_W  fetch address, equal to pc while imem_req=1
- imem_valid  in  1  imem_data valid this cycle (only sampled in FETCH)
- imem_data  in  16  instruction word
- operands  out  12  IR[11:0] to DataPath
- ctrl_sig  out  CtrlSig  decoded control to DataPath
- pc  out  PC_W  current program counter
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT

Behaviour:
- Reset (synchronous, active-high): the following values apply:
  - state=IDLE, pc=RESET_PC, IR=0
  - imem_req=0, busy=0, halted=0
  - ctrl_sig all-zero (`reg_wr_en`=0, `dst_in_sel`=0, `alu_cmd`=`ctrl::ALU_CMD_DEFAULT`)
  - Reset has priority over every other input in the same cycle.
- Instruction format: opcode=IR[15:12], operands=IR[11:0] (dst=[11:8], src1=[7:4], src2/n=[3:0], imm=[7:0]).
- Opcodes:
  - 0x0 NOP: no write.
  - 0x1–0x8 ALU: `alu_cmd` = `ctrl::op_to_alu(opcode)`, `dst_in_sel`=0, `reg_wr_en`=1.
  - 0x9 LDI: `dst_in_sel`=1, `reg_wr_en`=1.
  - 0xA–0xD reserved: execute as NOP.
  - 0xE JMP: pc<=IR[PC_W-1:0], no write.
  - 0xF HLT: enter HALT, no write.
- States:
  - IDLE: imem_req=0. Go to FETCH when run=1.
  - FETCH: imem_req=1, imem_addr=pc. Stay until imem_valid=1. On that edge, IR<=imem_data and go to EXEC. No timeout.
  - EXEC (exactly 1 cycle): ctrl_sig decoded from IR. `reg_wr_en` may be 1 only in this state.
    - Next pc: pc+1 modulo 2^PC_W, except JMP (target) and HLT (pc unchanged).
    - Next state: HLT -> HALT; otherwise FETCH if run=1, else IDLE.
  - HALT: all outputs quiescent, halted=1. Exit only by rst.
- Latency: with zero-wait memory (imem_valid the cycle after imem_req rises), one instruction every 2 cycles. Each memory wait cycle adds 1.
- Outside EXEC, ctrl_sig is all-zero and `reg_wr_en`=0.
- operands = IR[11:0] at all times; it stays stable through EXEC.
- imem_valid outside FETCH is ignored.
- Dropping run during FETCH does not cancel the fetch; the instruction still executes.
- Wrap: pc=2^PC_W-1 followed by a non-jump instruction gives pc=0.
- JMP to its own address loops forever without error.
- Reset mid-FETCH: imem_req drops the cycle after rst. A late imem_valid arriving in IDLE is ignored.

Decomposition:
- Package `ctrl` (existing) gains:
  - opcode constants OP_NOP, OP_LDI, OP_JMP, OP_HLT, OP_ALU_FIRST/LAST
  - `ALU_CMD_DEFAULT`
  - `op_to_alu()` function
  - state enum `SeqState`
- One sub-module, `instr_decode`: combinational, maps IR[15:12] plus an exec qualifier to CtrlSig plus is_jmp / is_hlt.
- pc, IR and FSM stay in `dp_sequencer`.
- Integration: `ctrl_sig` and `operands` connect directly to DataPath.

Test Plan:
- Reset then run=1, memory zero-wait returning 0x9305 at addr 0:
  - imem_req=1, addr=0.
  - Next EXEC cycle: reg_wr_en=1, dst_in_sel=1, operands=0x305.
  - pc becomes 1.
- ALU instruction 0x1412 with 3 wait cycles:
  - imem_req held 4 cycles at the same address.
  - EXEC: reg_wr_en=1, dst_in_sel=0, alu_cmd=op_to_alu(1).
  - Exactly one write pulse.
- Program {0x0000 @0, 0xE0FE @1, 0x0000 @FE, 0x0000 @FF, 0xF000 @0}:
  - pc sequence 0,1,FE,FF,0.
  - Then halted=1, busy=0, imem_req=0.
  - Stays halted with run=1 for 10 cycles.
- Reserved opcode 0xB123: no reg_wr_en, pc increments by 1.
- run dropped mid-FETCH:
  - Fetched instruction executes.
  - FSM goes to IDLE, imem_req=0.
  - Reasserting run resumes at pc+1.
- rst asserted during FETCH with imem_valid arriving the next cycle:
  - state IDLE, pc=RESET_PC, IR=0, no reg_wr_en.
- rst in HALT: returns to IDLE, halted=0.
